// File: rtl/tg68k_fpu_pkg.sv
// Shared types, ROM offset map and the offset-legality predicate for the FPU constant sequencer.
package tg68k_fpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } seq_state_e;

  // Extended precision: sign, 15-bit biased exponent, 64-bit explicit-integer mantissa.
  typedef struct packed {
    logic        sign;
    logic [14:0] exp;
    logic [63:0] mant;
  } fp_ext_t;

  localparam logic [6:0] OffPi          = 7'h00;
  localparam logic [6:0] OffLog10Two    = 7'h0B;
  localparam logic [6:0] OffE           = 7'h0C;
  localparam logic [6:0] OffLog2E       = 7'h0D;
  localparam logic [6:0] OffLog10E      = 7'h0E;
  localparam logic [6:0] OffZero        = 7'h0F;
  localparam logic [6:0] OffLn2         = 7'h30;
  localparam logic [6:0] OffLn10        = 7'h31;
  localparam logic [6:0] OffOne         = 7'h32;
  localparam logic [6:0] OffTenPowBase  = 7'h33;
  localparam logic [6:0] OffTenPowLast  = 7'h3F;

  function automatic logic is_undef_offset(input logic [6:0] off);
    return !(off inside {OffPi, OffLog10Two, OffE, OffLog2E, OffLog10E, OffZero,
                         OffLn2, OffLn10, OffOne, [OffTenPowBase:OffTenPowLast]});
  endfunction

endpackage

// File: rtl/tg68k_fpu_const_sequencer_if.sv
// Requester, response and constant-ROM signals of the FPU constant sequencer.
interface tg68k_fpu_const_sequencer_if;
  import tg68k_fpu_pkg::*;

  logic       req_a_valid;
  logic [6:0] req_a_offset;
  logic       req_b_valid;
  logic [6:0] req_b_offset;
  logic       ack_a;
  logic       ack_b;
  fp_ext_t    resp_data;
  logic       resp_undef;
  logic       busy;
  logic [6:0] rom_offset;
  logic       rom_read_enable;
  fp_ext_t    rom_constant_out;
  logic       rom_constant_valid;
  logic       proto_err;

  modport slave (
    input  req_a_valid, req_a_offset, req_b_valid, req_b_offset,
    input  rom_constant_out, rom_constant_valid,
    output ack_a, ack_b, resp_data, resp_undef, busy,
    output rom_offset, rom_read_enable, proto_err
  );

  modport master (
    output req_a_valid, req_a_offset, req_b_valid, req_b_offset,
    output rom_constant_out, rom_constant_valid,
    input  ack_a, ack_b, resp_data, resp_undef, busy,
    input  rom_offset, rom_read_enable, proto_err
  );

endinterface

// File: rtl/tg68k_fpu_const_rr_arb.sv
// Two-way round-robin arbiter; last_grant advances only when the owner accepts the grant.
module tg68k_fpu_const_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_grant_valid,
  output logic o_grant_b
);

  logic r_last_b;

  always_comb begin
    o_grant_valid = i_req_a | i_req_b;
    // B wins alone, or on a tie when A was served last.
    o_grant_b     = i_req_b & (~i_req_a | ~r_last_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (i_update) begin
      r_last_b <= o_grant_b;
    end
  end

endmodule

// File: rtl/tg68k_fpu_const_sequencer.sv
// Shares the FPU constant ROM between FMOVECR (A) and the microcode engine (B).
// FPU_CONST_CACHE_EN adds a one-entry constant cache that bypasses the ROM on a hit.
module tg68k_fpu_const_sequencer
  import tg68k_fpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  tg68k_fpu_const_sequencer_if.slave  bus
);

  seq_state_e r_state, w_state_next;

  logic       w_grant_valid;
  logic       w_grant_b;
  logic       w_arb_update;
  logic [6:0] w_grant_off;
  logic       w_hit;
  fp_ext_t    w_hit_data;
  logic       w_hit_undef;
  logic       w_cap_undef;
  fp_ext_t    w_cap_data;

  logic       r_gnt_b;
  logic [6:0] r_off;
  logic       r_ack_a;
  logic       r_ack_b;
  fp_ext_t    r_resp_data;
  logic       r_resp_undef;
  logic       r_busy;
  logic [6:0] r_rom_offset;
  logic       r_rom_re;
  logic       r_proto_err;

  tg68k_fpu_const_rr_arb u_arb (
    .clk           (clk),
    .reset         (reset),
    .i_req_a       (bus.req_a_valid),
    .i_req_b       (bus.req_b_valid),
    .i_update      (w_arb_update),
    .o_grant_valid (w_grant_valid),
    .o_grant_b     (w_grant_b)
  );

  assign w_grant_off = w_grant_b ? bus.req_b_offset : bus.req_a_offset;
  assign w_cap_undef = is_undef_offset(r_off);
  // A missing ROM valid or an undefined offset both return zero.
  assign w_cap_data  = (bus.rom_constant_valid && !w_cap_undef) ? bus.rom_constant_out : '0;

`ifdef FPU_CONST_CACHE_EN
  logic       r_c_valid;
  logic [6:0] r_c_off;
  fp_ext_t    r_c_data;
  logic       r_c_undef;

  assign w_hit       = r_c_valid && (r_c_off == w_grant_off);
  assign w_hit_data  = r_c_data;
  assign w_hit_undef = r_c_undef;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_valid <= 1'b0;
      r_c_off   <= '0;
      r_c_data  <= '0;
      r_c_undef <= 1'b0;
    end else if (r_state == StCapture) begin
      r_c_valid <= 1'b1;
      r_c_off   <= r_off;
      r_c_data  <= w_cap_data;
      r_c_undef <= w_cap_undef;
    end
  end
`else
  assign w_hit       = 1'b0;
  assign w_hit_data  = '0;
  assign w_hit_undef = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_arb_update = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant_valid) begin
          w_arb_update = 1'b1;
          w_state_next = w_hit ? StResp : StIssue;
        end
      end
      StIssue:   w_state_next = StCapture;
      StCapture: w_state_next = StResp;
      StResp:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_gnt_b      <= 1'b0;
      r_off        <= '0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_resp_data  <= '0;
      r_resp_undef <= 1'b0;
      r_busy       <= 1'b0;
      r_rom_offset <= '0;
      r_rom_re     <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_busy   <= (w_state_next != StIdle);
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_rom_re <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_valid) begin
            r_gnt_b <= w_grant_b;
            r_off   <= w_grant_off;
            if (w_hit) begin
              r_resp_data  <= w_hit_data;
              r_resp_undef <= w_hit_undef;
              r_ack_a      <= ~w_grant_b;
              r_ack_b      <= w_grant_b;
            end else begin
              r_rom_re     <= 1'b1;
              r_rom_offset <= w_grant_off;
            end
          end
        end
        StCapture: begin
          r_resp_data  <= w_cap_data;
          r_resp_undef <= w_cap_undef;
          r_ack_a      <= ~r_gnt_b;
          r_ack_b      <= r_gnt_b;
          if (!bus.rom_constant_valid) begin
            r_proto_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack_a           = r_ack_a;
  assign bus.ack_b           = r_ack_b;
  assign bus.resp_data       = r_resp_data;
  assign bus.resp_undef      = r_resp_undef;
  assign bus.busy            = r_busy;
  assign bus.rom_offset      = r_rom_offset;
  assign bus.rom_read_enable = r_rom_re;
  assign bus.proto_err       = r_proto_err;

endmodule

// File: tb/tb_tg68k_fpu_const_sequencer.sv
// Self-checking bench: transaction-level timeline model plus directed literal checks and random traffic.
`timescale 1ns/1ps
module tb_tg68k_fpu_const_sequencer;
  import tg68k_fpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic kill = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  tg68k_fpu_const_sequencer_if bus ();

  tg68k_fpu_const_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] rom_val(input logic [6:0] off);
    case (off)
      7'h00:   return 80'h4000C90FDAA22168C235;
      7'h0C:   return 80'h4000ADF85458A2BB4A9A;
      7'h32:   return 80'h3FFF8000000000000000;
      7'h0F:   return 80'h0;
      default: return {9'h155, off, 57'h0ABCDEF1234567, off};
    endcase
  endfunction

  function automatic bit model_undef(input int o);
    return !(o == 0 || (o >= 11 && o <= 15) || (o >= 48 && o <= 63));
  endfunction

  // Registered ROM: data/valid one cycle after read enable; kill suppresses valid.
  always @(posedge clk) begin
    if (reset) begin
      bus.rom_constant_valid <= 1'b0;
      bus.rom_constant_out   <= '0;
    end else begin
      bus.rom_constant_valid <= bus.rom_read_enable && !kill;
      if (bus.rom_read_enable) bus.rom_constant_out <= rom_val(bus.rom_offset);
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline model: a grant at cycle g yields read enable at g+1 and ack at g+3 (g+1 on a hit).
  int unsigned c = 0;
  int unsigned g_cyc = 0;
  int unsigned ack_cyc = 0;
  bit          armed = 0;
  bit          pend = 0;
  bit          m_hit = 0;
  bit          m_b = 0;
  bit          last_b = 1;
  bit          m_perr_set = 0;
  bit          ack_now, re_now, busy_now;
  logic [79:0] m_data = '0;
  logic [79:0] held_data = '0;
  logic        m_undef = 1'b0;
  logic        held_undef = 1'b0;
  logic        exp_perr = 1'b0;
  logic [6:0]  m_off = '0;
  logic [6:0]  exp_rom_off = '0;
  bit          c_valid = 0;
  logic [6:0]  c_off = '0;
  logic [79:0] c_data = '0;
  logic        c_undef = 1'b0;

  always @(negedge clk) begin
    c++;
    if (armed) begin
      ack_now  = pend && (c == ack_cyc);
      re_now   = pend && !m_hit && (c == g_cyc + 1);
      busy_now = pend && (c > g_cyc) && (c <= ack_cyc);
      if (re_now) exp_rom_off = m_off;
      if (ack_now) begin
        held_data  = m_data;
        held_undef = m_undef;
        if (m_perr_set) exp_perr = 1'b1;
      end
      chk_bit("ack_a", bus.ack_a, ack_now && !m_b);
      chk_bit("ack_b", bus.ack_b, ack_now && m_b);
      chk_bit("rom_re", bus.rom_read_enable, re_now);
      chk_bit("busy", bus.busy, busy_now);
      chk_bit("proto_err", bus.proto_err, exp_perr);
      chk("resp_data", bus.resp_data, held_data);
      chk_bit("resp_undef", bus.resp_undef, held_undef);
      chk("rom_offset", 80'(bus.rom_offset), 80'(exp_rom_off));
    end
    if (reset) begin
      armed = 1; pend = 0; last_b = 1; c_valid = 0;
      held_data = '0; held_undef = 1'b0; exp_perr = 1'b0; exp_rom_off = '0;
    end else if (pend && c == ack_cyc) begin
      pend = 0;
      if (!m_hit) begin
        c_valid = 1; c_off = m_off; c_data = m_data; c_undef = m_undef;
      end
    end else if (!pend && (bus.req_a_valid || bus.req_b_valid)) begin
      m_b    = bus.req_b_valid && (!bus.req_a_valid || !last_b);
      last_b = m_b;
      m_off  = m_b ? bus.req_b_offset : bus.req_a_offset;
      pend   = 1;
      g_cyc  = c;
      m_perr_set = 0;
`ifdef FPU_CONST_CACHE_EN
      m_hit = c_valid && (c_off == m_off);
`else
      m_hit = 0;
`endif
      if (m_hit) begin
        ack_cyc = c + 1;
        m_data  = c_data;
        m_undef = c_undef;
      end else begin
        ack_cyc    = c + 3;
        m_undef    = model_undef(int'(m_off));
        m_perr_set = kill;
        m_data     = (m_undef || kill) ? 80'h0 : rom_val(m_off);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input bit is_b, output int n, output bit saw_re);
    n = 0;
    saw_re = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (bus.rom_read_enable) saw_re = 1;
    end while (!(is_b ? bus.ack_b : bus.ack_a) && n < 12);
  endtask

  task automatic req_one(input bit is_b, input logic [6:0] off, input int exp_lat,
                         input logic [79:0] exp_data, input logic exp_undef,
                         input string name, output bit saw_re);
    int n;
    if (is_b) begin
      bus.req_b_valid = 1'b1; bus.req_b_offset = off;
    end else begin
      bus.req_a_valid = 1'b1; bus.req_a_offset = off;
    end
    wait_ack(is_b, n, saw_re);
    chk_int({name, "_lat"}, n, exp_lat);
    chk({name, "_data"}, bus.resp_data, exp_data);
    chk_bit({name, "_undef"}, bus.resp_undef, exp_undef);
    #1;
    if (is_b) bus.req_b_valid = 1'b0;
    else bus.req_a_valid = 1'b0;
    tick();
  endtask

  function automatic logic [6:0] pick_off();
    case ($urandom_range(7))
      0:       return 7'h00;
      1:       return 7'h0F;
      2:       return 7'h32;
      3:       return 7'h0C;
      4:       return 7'h05;
      default: return 7'($urandom_range(127));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, na, nb;
    bit  saw_re;
    bus.req_a_valid = 1'b0; bus.req_a_offset = '0;
    bus.req_b_valid = 1'b0; bus.req_b_offset = '0;
    do_reset(3);

    req_one(1'b0, 7'h00, 3, 80'h4000C90FDAA22168C235, 1'b0, "a_pi", saw_re);
    chk_bit("a_pi_rom_re", saw_re, 1'b1);

    // Tie right after reset: A first, B served by the next idle sample.
    do_reset(2);
    bus.req_a_valid = 1'b1; bus.req_a_offset = 7'h32;
    bus.req_b_valid = 1'b1; bus.req_b_offset = 7'h0C;
    na = 0; nb = 0; n = 0;
    while ((na == 0 || nb == 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ack_a) begin
        na = n;
        chk("tie_a_data", bus.resp_data, 80'h3FFF8000000000000000);
      end
      if (bus.ack_b) begin
        nb = n;
        chk("tie_b_data", bus.resp_data, 80'h4000ADF85458A2BB4A9A);
      end
      #1;
      if (na != 0) bus.req_a_valid = 1'b0;
      if (nb != 0) bus.req_b_valid = 1'b0;
    end
    chk_int("tie_a_lat", na, 3);
    chk_int("tie_b_lat", nb, 7);
    tick();

    req_one(1'b1, 7'h05, 3, 80'h0, 1'b1, "b_undef", saw_re);

    // Reset while in CAPTURE; A keeps holding its request.
    bus.req_a_valid = 1'b1; bus.req_a_offset = 7'h0C;
    tick();
    tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("rst_no_ack", bus.ack_a, 1'b0);
    chk_bit("rst_busy", bus.busy, 1'b0);
    #1;
    reset = 1'b0;
    wait_ack(1'b0, n, saw_re);
    chk_int("rst_retry_lat", n, 3);
    chk("rst_retry_data", bus.resp_data, 80'h4000ADF85458A2BB4A9A);
    #1;
    bus.req_a_valid = 1'b0;
    tick();

    do_reset(2);
    req_one(1'b0, 7'h0F, 3, 80'h0, 1'b0, "zero_1st", saw_re);
`ifdef FPU_CONST_CACHE_EN
    req_one(1'b0, 7'h0F, 1, 80'h0, 1'b0, "zero_2nd", saw_re);
    chk_bit("zero_2nd_rom_re", saw_re, 1'b0);
`else
    req_one(1'b0, 7'h0F, 3, 80'h0, 1'b0, "zero_2nd", saw_re);
    chk_bit("zero_2nd_rom_re", saw_re, 1'b1);
`endif

    do_reset(2);
    kill = 1'b1;
    req_one(1'b0, 7'h32, 3, 80'h0, 1'b0, "perr", saw_re);
    chk_bit("perr_set", bus.proto_err, 1'b1);
    kill = 1'b0;
    req_one(1'b1, 7'h00, 3, 80'h4000C90FDAA22168C235, 1'b0, "perr_next", saw_re);
    chk_bit("perr_sticky", bus.proto_err, 1'b1);
    do_reset(2);
    chk_bit("perr_clear", bus.proto_err, 1'b0);

    repeat (3000) begin
      if (bus.ack_a) bus.req_a_valid = 1'b0;
      else if (!bus.req_a_valid && $urandom_range(3) == 0) begin
        bus.req_a_valid = 1'b1; bus.req_a_offset = pick_off();
      end
      if (bus.ack_b) bus.req_b_valid = 1'b0;
      else if (!bus.req_b_valid && $urandom_range(3) == 0) begin
        bus.req_b_valid = 1'b1; bus.req_b_offset = pick_off();
      end
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0;
    bus.req_a_valid = 1'b0;
    bus.req_b_valid = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tg68k_fpu_const_sequencer.md
# tg68k_fpu_const_sequencer

Sequencer and two-way arbiter in front of the FPU constant ROM. It shares the single ROM read port between the FMOVECR execution path (requester A) and the transcendental/microcode engine (requester B). It drives the ROM's offset and read-enable, captures the registered 80-bit extended constant, and returns it to the granted requester with a one-cycle acknowledge. It also flags offsets that are not defined constants.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_a_valid  in  1  FMOVECR request; held with offset until ack_a
- req_a_offset  in  7  FMOVECR ROM offset
- req_b_valid  in  1  engine request; held with offset until ack_b
- req_b_offset  in  7  engine ROM offset
- ack_a / ack_b  out  1  one-cycle response strobe to the granted requester
- resp_data  out  80  constant (sign/exp15/mantissa64), held until next response
- resp_undef  out  1  offset not in {0x00, 0x0B–0x0F, 0x30–0x3F}; data is zero
- busy  out  1  state != IDLE
- rom_offset  out  7  to ROM
- rom_read_enable  out  1  to ROM
- rom_constant_out  in  80  from ROM, registered, valid the cycle after read_enable
- rom_constant_valid  in  1  from ROM
- proto_err  out  1  sticky; ROM valid missing in CAPTURE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any req_*_valid, grant via round-robin, latch offset and grant id → ISSUE. Otherwise stay.
- Round-robin: a single-requester request always wins. When both request, the requester not granted last wins. The last_grant register resets to B, so A wins the first tie.
- ISSUE: rom_read_enable=1, rom_offset=latched offset → CAPTURE.
- CAPTURE: if rom_constant_valid, latch rom_constant_out into resp_data. If not, set proto_err and latch zero. Compute resp_undef from the latched offset; when undefined, force resp_data to zero. → RESP.
- RESP: assert ack of the granted id → IDLE. Requests are not sampled in RESP, so a requester that drops valid after its ack is never re-granted.
- Requester dropping valid before its ack is illegal. The sequencer still completes and acks that requester.
- rom_read_enable is 0 and rom_offset holds its last value outside ISSUE.

## Timing
- Reset values: ack_a=0, ack_b=0, resp_data=0, resp_undef=0, busy=0, rom_offset=0, rom_read_enable=0, proto_err=0, state=IDLE, last_grant=B.
- All outputs are registered.
- Miss latency: request sampled in IDLE at cycle T, rom_read_enable at T+1, capture at T+2, ack at T+3. The next grant is no earlier than T+4 (4-cycle throughput).
- Simultaneous A and B requests in IDLE: one is granted; the loser is served by the next IDLE sample, typically at T+4.
- Reset asserted mid-operation: the cycle after reset, state is IDLE and no ack is issued. The pending request is lost, and the requester must still hold valid.

## Configuration
- FPU_CONST_CACHE_EN defined:
  - Adds a one-entry cache (valid, offset, data, undef), filled on every CAPTURE.
  - An IDLE grant whose offset matches a valid entry goes directly to RESP with the cached data. Ack comes at T+1, with no ROM access.
  - The cache is invalidated by reset.
- Undefined: no cache; every request takes the full ROM path.

## Structure
- Shared package tg68k_fpu_pkg:
  - state enum
  - 80-bit extended type
  - constant-offset localparams (PI=0x00, LOG10_2=0x0B, E=0x0C, LOG2_E=0x0D, LOG10_E=0x0E, ZERO=0x0F, LN2=0x30, ONE=0x32, TEN_POW base 0x33–0x3F)
  - undefined-offset predicate function
- Sub-module tg68k_fpu_const_rr_arb: 2-way round-robin grant with last_grant register and an update strobe.

## Test plan
- A only, offset 0x00 → ack_a at T+3, resp_data=0x4000C90FDAA22168C235, resp_undef=0.
- A and B simultaneous after reset, A=0x32, B=0x0C → ack_a with 0x3FFF8000000000000000, then ack_b with 0x4000ADF85458A2BB4A9A.
- B offset 0x05 → ack_b at T+3, resp_data=0, resp_undef=1.
- Reset asserted in CAPTURE → no ack; busy=0 next cycle. Re-held request completes normally.
- With FPU_CONST_CACHE_EN, A requests 0x0F twice → second ack at T+1, rom_read_enable stays 0. Without the macro, the second ack is at T+3.
- Force rom_constant_valid=0 in CAPTURE → proto_err=1 (sticky), resp_data=0, ack still issued.
